// File: rtl/tetris_pkg.sv
// Shared playfield definitions for the lock/clear slice: board geometry,
// pixel origin of the playfield, cell size, the "playing" gamestate code,
// the board storage types and the lock/clear sequencer states.
package tetris_pkg;

  localparam int unsigned BOARD_COLS     = 10;
  localparam int unsigned BOARD_ROWS     = 20;
  localparam logic [9:0]  X_ORIGIN       = 10'd250;
  localparam logic [9:0]  Y_ORIGIN       = 10'd100;
  localparam int unsigned CELL_SHIFT     = 4;
  localparam logic [1:0]  GAMESTATE_PLAY = 2'd2;

  typedef logic [BOARD_COLS-1:0] row_t;
  typedef row_t [BOARD_ROWS-1:0] board_t;

  typedef enum logic [2:0] {
    IDLE,
    LOCK,
    SCAN,
    SHIFT,
    DONE
  } lock_state_t;

endpackage

// File: rtl/board_stamp.sv
// Combinational shape stamper.
//   board_in  : current playfield
//   col0/row0 : cell coordinates of the shape's top-left cell (may be huge
//               after an underflowing pixel subtraction)
//   mask      : bit 4*i+j = shape cell at row i, column j
//   board_out : board_in with the shape cells ORed in; cells that fall
//               outside the playfield are dropped.
module board_stamp
  import tetris_pkg::*;
(
  input  board_t      board_in,
  input  logic [9:0]  col0,
  input  logic [9:0]  row0,
  input  logic [15:0] mask,
  output board_t      board_out
);

  logic [10:0] dr;
  logic [10:0] dc;

  // Work from the board cell back to the shape offset: an 11-bit difference
  // that wraps when the shape origin lies right/below the cell, so only
  // offsets 0..3 select a mask bit and nothing can alias back on-board.
  always_comb begin
    board_out = board_in;
    dr = '0;
    dc = '0;
    for (int unsigned r = 0; r < BOARD_ROWS; r++) begin
      for (int unsigned c = 0; c < BOARD_COLS; c++) begin
        dr = 11'(r) - {1'b0, row0};
        dc = 11'(c) - {1'b0, col0};
        if ((dr < 11'd4) && (dc < 11'd4) && mask[{dr[1:0], dc[1:0]}])
          board_out[r][c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_lock_clear.sv
// Playfield lock and line clear.
// On a rising touchdown edge (while idle, playing and not game over) the
// landed shape is stamped into the board, every row is scanned bottom-up,
// full rows are removed with the rows above dropping down, and a one-cycle
// ResetShape pulse respawns the block.
//   Reset/decis_clk  : async active-high reset, clock
//   reset_game       : synchronous clear of board, score, game-over, sequence
//   gamestate        : locks accepted only in GAMESTATE_PLAY
//   touchdown        : level from the mover
//   shape_x/shape_y  : pixel position of the shape's top-left cell
//   shape_mask       : 4x4 shape cells
//   row_rd_idx/data  : combinational renderer row read (0 beyond the board)
//   Score            : lines cleared, saturating
//   ResetShape       : respawn pulse
//   game_over        : sticky, set when row 0 is occupied after a lock
//   busy             : sequence in progress
module board_lock_clear
  import tetris_pkg::*;
(
  input  logic        Reset,
  input  logic        decis_clk,
  input  logic        reset_game,
  input  logic [1:0]  gamestate,
  input  logic        touchdown,
  input  logic [9:0]  shape_x,
  input  logic [9:0]  shape_y,
  input  logic [15:0] shape_mask,
  input  logic [4:0]  row_rd_idx,
  output logic [9:0]  row_rd_data,
  output logic [13:0] Score,
  output logic        ResetShape,
  output logic        game_over,
  output logic        busy
);

  localparam logic [4:0] LAST_ROW = 5'(BOARD_ROWS - 1);

  lock_state_t state, state_next;
  board_t      board, board_stamped;
  logic        td_q;
  logic [9:0]  col0_q, row0_q;
  logic [15:0] mask_q;
  logic [4:0]  r_q;
  logic        start;
  logic        row_full;

  assign start    = touchdown & ~td_q & (state == IDLE) &
                    (gamestate == GAMESTATE_PLAY) & ~game_over;
  assign row_full = (board[r_q] == '1);

  board_stamp u_stamp (
    .board_in  (board),
    .col0      (col0_q),
    .row0      (row0_q),
    .mask      (mask_q),
    .board_out (board_stamped)
  );

  always_ff @(posedge decis_clk or posedge Reset) begin
    if (Reset)           state <= IDLE;
    else if (reset_game) state <= IDLE;
    else                 state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = LOCK;
      LOCK:  state_next = SCAN;
      SCAN: begin
        if (row_full)          state_next = SHIFT;
        else if (r_q == 5'd0)  state_next = DONE;
      end
      SHIFT: state_next = SCAN;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    row_rd_data = '0;
    if (row_rd_idx < 5'(BOARD_ROWS))
      row_rd_data = board[row_rd_idx];
  end

  always_ff @(posedge decis_clk or posedge Reset) begin
    if (Reset) begin
      board      <= '0;
      Score      <= '0;
      ResetShape <= 1'b0;
      game_over  <= 1'b0;
      td_q       <= 1'b0;
      r_q        <= '0;
      col0_q     <= '0;
      row0_q     <= '0;
      mask_q     <= '0;
    end else if (reset_game) begin
      board      <= '0;
      Score      <= '0;
      ResetShape <= 1'b0;
      game_over  <= 1'b0;
      td_q       <= 1'b0;
      r_q        <= '0;
      col0_q     <= '0;
      row0_q     <= '0;
      mask_q     <= '0;
    end else begin
      td_q <= touchdown;
      // Registered pulse that lines up with the DONE state cycle.
      ResetShape <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            col0_q <= (shape_x - X_ORIGIN) >> CELL_SHIFT;
            row0_q <= (shape_y - Y_ORIGIN) >> CELL_SHIFT;
            mask_q <= shape_mask;
          end
        end
        LOCK: begin
          board <= board_stamped;
          r_q   <= LAST_ROW;
        end
        SCAN: begin
          if (!row_full && (r_q != 5'd0))
            r_q <= r_q - 5'd1;
        end
        SHIFT: begin
          // r_q is held so the row that dropped into it is scanned again.
          for (int unsigned k = 1; k < BOARD_ROWS; k++) begin
            if (5'(k) <= r_q)
              board[k] <= board[k-1];
          end
          board[0] <= '0;
          if (Score != '1)
            Score <= Score + 14'd1;
        end
        DONE: begin
          if (board[0] != '0)
            game_over <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
